button_irq_master: RTL and testbench
====================================

BUTTON_IRQ_MASTER -- requirements
Module: button_irq_master

Interface
REQ-001 SHALL have parameter IRQ_MASK, default 8'hFF: value written to the PIO interrupt-mask register at init.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16): event FIFO entries.
REQ-003 SHALL have one clock and an asynchronous active-low reset; no other clock or reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 address  out  2  Avalon-MM master address to the button PIO slave.
REQ-007 chipselect  out  1  slave select.
REQ-008 write_n  out  1  active-low write strobe.
REQ-009 writedata  out  8  write data.
REQ-010 readdata  in  8  slave read data, registered in the slave: valid one cycle after address is presented.
REQ-011 irq  in  1  level interrupt from the slave.
REQ-012 evt_data  out  8  captured edge bits, FIFO head.
REQ-013 evt_valid  out  1  FIFO non-empty.
REQ-014 evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
REQ-015 overflow  out  1  sticky: an event was dropped because the FIFO was full.
REQ-016 init_done  out  1  high once the mask write has completed.

Function
REQ-017 SHALL be a Moore FSM with states INIT_MASK, IDLE, RD_ADDR, RD_DATA, CLEAR, SETTLE; bus outputs decoded only from the state register.
REQ-018 INIT_MASK: chipselect=1, write_n=0, address=2, writedata=IRQ_MASK for exactly one cycle, then go to IDLE and set init_done.
REQ-019 IDLE: chipselect=0, write_n=1, address=0, writedata=0; if irq=1, go to RD_ADDR.
REQ-020 RD_ADDR: chipselect=1, write_n=1, address=3 for one cycle, then go to RD_DATA.
REQ-021 RD_DATA: address=3 held; sample readdata at the clock edge; go to CLEAR.
REQ-022 Sampled value nonzero and FIFO not full: push it.
REQ-023 Sampled value nonzero and FIFO full (after any same-cycle pop): drop it and set overflow.
REQ-024 Sampled value zero (spurious irq): no push, no overflow.
REQ-025 CLEAR: chipselect=1, write_n=0, address=3, writedata=8'hFF for one cycle, then go to SETTLE.
REQ-026 SETTLE: bus idle for one cycle so the slave irq can deassert, then go to IDLE.
REQ-027 Latency: irq sampled high in IDLE at edge N -> RD_ADDR during cycle N+1, push at edge N+2, evt_valid high from cycle N+3 if the FIFO was empty.
REQ-028 Edges arriving between the RD_DATA sample and the CLEAR write are cleared by the slave and lost; this is accepted behaviour, not an error.
REQ-029 Simultaneous push and pop SHALL both succeed; the count is unchanged; a full FIFO with a same-cycle pop accepts the push.
REQ-030 FIFO SHALL be first-in first-out; read and write pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-031 Pop when empty SHALL be ignored; evt_data SHALL be 0 when empty.
REQ-032 overflow SHALL clear only on reset.
REQ-033 irq during any non-IDLE state SHALL be ignored until IDLE is re-entered; a still-high irq in IDLE retriggers the sequence.

Reset
REQ-034 On reset_n=0, state=INIT_MASK, FIFO empty, overflow=0, init_done=0, evt_valid=0, evt_data=0.
REQ-035 While reset_n=0, outputs SHALL be chipselect=0, write_n=1, address=0, writedata=0; the INIT_MASK write occurs in the first cycle after release.
REQ-036 Reset mid-sequence SHALL abandon the sequence, discard FIFO contents, and re-run INIT_MASK.

Structure
REQ-037 A shared package button_pkg SHALL hold the state enum and address constants: ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
REQ-038 The FIFO SHALL be a sub-module named button_evt_fifo (parameter FIFO_DEPTH, 8-bit data), instantiated once.

Verification
REQ-039 Release reset, irq=0 -> exactly one write {address 2, writedata 8'hFF} in cycle 1, then init_done=1 and the bus idle.
REQ-040 Slave model sets edge_capture=8'h05 and raises irq -> read at address 3, evt_data=8'h05 and evt_valid=1 at N+3, then write {address 3, 8'hFF}, irq drops.
REQ-041 evt_ready=0, five irq events 01,02,04,08,10 -> FIFO holds 01,02,04,08; overflow=1; pops return them in order.
REQ-042 irq with edge_capture=0 -> full read/clear sequence, no push, overflow=0.
REQ-043 FIFO full and evt_ready=1 in the same cycle as the RD_DATA push -> push accepted, overflow stays 0.
REQ-044 reset_n pulsed low during RD_DATA -> FIFO empties, overflow=0, mask write repeats after release.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the button PIO interrupt master: FSM states,
// PIO register map and the Avalon bus-cycle encoding used by each state.
package button_pkg;

    localparam int EVT_W = 8;

    typedef enum logic [2:0] {
        ST_INIT_MASK,
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_CLEAR,
        ST_SETTLE
    } state_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam logic [EVT_W-1:0] EDGE_CLEAR_ALL = 8'hFF;

    typedef struct packed {
        logic             chipselect;
        logic             write_n;
        logic [1:0]       address;
        logic [EVT_W-1:0] writedata;
    } bus_t;

    localparam bus_t BUS_IDLE = '{
        chipselect: 1'b0,
        write_n:    1'b1,
        address:    ADDR_DATA,
        writedata:  8'h00
    };

    // Bus cycle driven while the FSM sits in a given state (Moore decode).
    function automatic bus_t bus_decode(input state_e st, input logic [EVT_W-1:0] mask);
        bus_t b;
        b = BUS_IDLE;
        case (st)
            ST_INIT_MASK: begin
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.address    = ADDR_MASK;
                b.writedata  = mask;
            end
            ST_RD_ADDR, ST_RD_DATA: begin
                b.chipselect = 1'b1;
                b.address    = ADDR_EDGE;
            end
            ST_CLEAR: begin
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.address    = ADDR_EDGE;
                b.writedata  = EDGE_CLEAR_ALL;
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/button_evt_fifo.sv
// Small event FIFO: push/pop in the same cycle always succeed, a full FIFO
// accepts a push when it is also popped, and a rejected push is flagged.
module button_evt_fifo
    import button_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = EVT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_drop,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty, full, do_push, do_pop;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == DEPTH_C);
        do_pop    = pop_ready && !empty;
        do_push   = push_valid && (!full || do_pop);
        push_drop = push_valid && !do_push;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Power-of-two depth: pointers wrap by natural overflow.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase

        head_valid = !empty;
        head_data  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/button_irq_master.sv
// Avalon-MM master servicing a button PIO: programs the interrupt mask, then on
// each irq reads and clears the edge-capture register and queues nonzero captures.
module button_irq_master
    import button_pkg::*;
#(
    parameter logic [7:0] IRQ_MASK   = 8'hFF,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [1:0] address,
    output logic       chipselect,
    output logic       write_n,
    output logic [7:0] writedata,
    input  logic [7:0] readdata,
    input  logic       irq,
    output logic [7:0] evt_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       overflow,
    output logic       init_done
);

    state_e state_q, state_d;
    logic   init_done_q, init_done_d;
    logic   overflow_q, overflow_d;
    logic   push_valid, push_drop;
    bus_t   bus;

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT_MASK: begin
                state_d     = ST_IDLE;
                init_done_d = 1'b1;
            end
            ST_IDLE: begin
                if (irq) begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_SETTLE;
            ST_SETTLE:  state_d = ST_IDLE;
            default:    state_d = ST_INIT_MASK;
        endcase
    end

    // readdata is valid in RD_DATA because the slave registers it one cycle after RD_ADDR.
    always_comb begin
        push_valid = (state_q == ST_RD_DATA) && (readdata != 8'h00);
    end

    always_comb begin
        overflow_d = overflow_q | push_drop;
    end

    // Bus held idle while in reset even though the state register already reads INIT_MASK.
    always_comb begin
        bus = reset_n ? bus_decode(state_q, IRQ_MASK) : BUS_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT_MASK;
            init_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            overflow_q  <= overflow_d;
        end
    end

    button_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (EVT_W)
    ) u_evt_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (push_valid),
        .push_data  (readdata),
        .push_drop  (push_drop),
        .pop_ready  (evt_ready),
        .head_data  (evt_data),
        .head_valid (evt_valid)
    );

    assign chipselect = bus.chipselect;
    assign write_n    = bus.write_n;
    assign address    = bus.address;
    assign writedata  = bus.writedata;
    assign overflow   = overflow_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_button_irq_master.sv
// Bench for button_irq_master: behavioural PIO slave, queue-based event model,
// directed scenarios followed by randomized event/pop traffic.
module tb_button_irq_master;

    localparam int         DEPTH = 4;
    localparam logic [7:0] MASK  = 8'hFF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] address;
    logic       chipselect, write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       irq;
    logic [7:0] evt_data;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic       overflow, init_done;

    int total = 0;
    int bad   = 0;

    button_irq_master #(.IRQ_MASK(MASK), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .evt_data   (evt_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .overflow   (overflow),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // PIO slave: registered readdata, mask register, edge capture with write-1-to-clear.
    logic [7:0] edge_cap, mask_reg;
    logic       spur_q;
    logic [7:0] inj_bits = 8'h00;
    logic       inj_spur = 1'b0;
    logic       clr_wr;
    assign clr_wr = chipselect && !write_n && (address == 2'd3);
    assign irq    = (|(edge_cap & mask_reg)) | spur_q;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= 8'h00;
            mask_reg <= 8'h00;
            readdata <= 8'h00;
            spur_q   <= 1'b0;
        end else begin
            readdata <= (chipselect && write_n) ?
                        ((address == 2'd3) ? edge_cap : (address == 2'd2) ? mask_reg : 8'h00) : 8'h00;
            if (chipselect && !write_n && address == 2'd2) mask_reg <= writedata;
            edge_cap <= (edge_cap & ~(clr_wr ? writedata : 8'h00)) | inj_bits;
            spur_q   <= (spur_q && !clr_wr) || inj_spur;
        end
    end

    int         wr_cnt = 0;
    logic [1:0] last_wa;
    logic [7:0] last_wd;
    always @(posedge clk) begin
        if (reset_n && chipselect && !write_n) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= address;
            last_wd <= writedata;
        end
    end

    // Reference model: queue of pending events plus sticky overflow flag.
    logic [7:0] mq[$];
    bit         m_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_head();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    // Caller positions at a negedge; asserts reset, checks reset outputs, releases, checks init write.
    task automatic do_reset();
        int w0;
        reset_n  = 1'b0;
        evt_ready = 1'b0;
        inj_bits = 8'h00;
        inj_spur = 1'b0;
        mq.delete();
        m_ovf = 0;
        @(negedge clk);
        check_val("rst_cs",    chipselect, 1'b0);
        check_val("rst_wn",    write_n,    1'b1);
        check_val("rst_addr",  address,    2'd0);
        check_val("rst_wd",    writedata,  8'h00);
        check_val("rst_valid", evt_valid,  1'b0);
        check_val("rst_data",  evt_data,   8'h00);
        check_val("rst_ovf",   overflow,   1'b0);
        check_val("rst_init",  init_done,  1'b0);
        w0 = wr_cnt;
        reset_n = 1'b1;
        #1;
        check_val("init_cs",   chipselect, 1'b1);
        check_val("init_wn",   write_n,    1'b0);
        check_val("init_addr", address,    2'd2);
        check_val("init_wd",   writedata,  MASK);
        @(negedge clk);
        check_val("init_done", init_done,  1'b1);
        check_val("idle_cs",   chipselect, 1'b0);
        check_val("idle_wn",   write_n,    1'b1);
        check_val("idle_addr", address,    2'd0);
        check_val("idle_wd",   writedata,  8'h00);
        repeat (3) @(negedge clk);
        check_val("init_wr_cnt", wr_cnt - w0, 1);
        check_val("init_wr_a",   last_wa, 2'd2);
        check_val("init_wr_d",   last_wd, MASK);
    endtask

    // One full irq service sequence with cycle-exact bus checks.
    task automatic run_event(input logic [7:0] v, input bit pop_rd, input bit abort);
        @(negedge clk);
        if (v == 8'h00) inj_spur = 1'b1; else inj_bits = v;
        @(posedge clk);
        #1;
        inj_bits = 8'h00;
        inj_spur = 1'b0;
        @(negedge clk);
        check_val("pre_irq", irq, 1'b1);
        check_val("pre_cs",  chipselect, 1'b0);
        @(negedge clk);
        check_val("rda_cs",   chipselect, 1'b1);
        check_val("rda_wn",   write_n,    1'b1);
        check_val("rda_addr", address,    2'd3);
        @(negedge clk);
        check_val("rdd_addr",  address,   2'd3);
        check_val("rdd_wn",    write_n,   1'b1);
        check_val("rdd_valid", evt_valid, mq.size() != 0);
        check_val("rdd_data",  evt_data,  m_head());
        if (abort) begin
            do_reset();
            return;
        end
        if (pop_rd) begin
            evt_ready = 1'b1;
            if (mq.size() != 0) void'(mq.pop_front());
        end
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        if (v != 8'h00) begin
            if (mq.size() < DEPTH) mq.push_back(v);
            else m_ovf = 1;
        end
        @(negedge clk);
        check_val("clr_cs",    chipselect, 1'b1);
        check_val("clr_wn",    write_n,    1'b0);
        check_val("clr_addr",  address,    2'd3);
        check_val("clr_wd",    writedata,  8'hFF);
        check_val("evt_valid", evt_valid,  mq.size() != 0);
        check_val("evt_data",  evt_data,   m_head());
        check_val("overflow",  overflow,   m_ovf);
        @(negedge clk);
        check_val("settle_cs",  chipselect, 1'b0);
        check_val("settle_irq", irq,        1'b0);
        @(negedge clk);
        check_val("back_idle_cs", chipselect, 1'b0);
    endtask

    task automatic pop_one();
        @(negedge clk);
        check_val("pop_valid", evt_valid, mq.size() != 0);
        check_val("pop_data",  evt_data,  m_head());
        evt_ready = 1'b1;
        if (mq.size() != 0) void'(mq.pop_front());
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq5 [5];
        seq5 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

        @(negedge clk);
        do_reset();

        // Spurious irq with empty capture: full sequence, nothing queued.
        run_event(8'h00, 1'b0, 1'b0);
        check_val("spur_valid", evt_valid, 1'b0);
        check_val("spur_ovf",   overflow,  1'b0);

        run_event(8'h05, 1'b0, 1'b0);
        check_val("ev05_wr_a", last_wa, 2'd3);
        check_val("ev05_wr_d", last_wd, 8'hFF);
        pop_one();

        for (int i = 0; i < 5; i++) run_event(seq5[i], 1'b0, 1'b0);
        check_val("fill_ovf", overflow, 1'b1);
        for (int i = 0; i < 5; i++) pop_one();
        check_val("drain_ovf", overflow, 1'b1);

        @(negedge clk);
        do_reset();

        // Full FIFO popped in the push cycle accepts the new event.
        run_event(8'h11, 1'b0, 1'b0);
        run_event(8'h22, 1'b0, 1'b0);
        run_event(8'h33, 1'b0, 1'b0);
        run_event(8'h44, 1'b0, 1'b0);
        run_event(8'h55, 1'b1, 1'b0);
        check_val("fullpop_ovf", overflow, 1'b0);
        run_event(8'h66, 1'b0, 1'b0);
        check_val("full_ovf", overflow, 1'b1);

        // Reset during RD_DATA abandons the sequence and empties everything.
        run_event(8'h77, 1'b0, 1'b1);
        check_val("abort_valid", evt_valid, 1'b0);
        check_val("abort_ovf",   overflow,  1'b0);

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            logic [7:0]  v;
            r = $urandom_range(0, 3);
            if (r < 3) begin
                v = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                run_event(v, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                pop_one();
            end
        end
        while (mq.size() != 0) pop_one();
        pop_one();
        @(negedge clk);
        check_val("final_ovf",   overflow,  m_ovf);
        check_val("final_valid", evt_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
